// File: rtl/hazard_ctrl_pkg.sv
// Shared types and encodings for the decode-stage hazard/forwarding controller.
//   - wd_sel writeback-source encodings (WD_*)
//   - rD*_sel forwarding-select encodings (FWD_*)
//   - sb_slot_t: one scoreboard slot {valid_we, rd, wd_sel}
package hazard_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned WD_W  = 2;
    localparam int unsigned SEL_W = 3;

    localparam logic [WD_W-1:0] WD_ALU  = 2'b00;
    localparam logic [WD_W-1:0] WD_DRAM = 2'b01;
    localparam logic [WD_W-1:0] WD_PC4  = 2'b10;
    localparam logic [WD_W-1:0] WD_IMM  = 2'b11;

    localparam logic [SEL_W-1:0] FWD_RF     = 3'b000;
    localparam logic [SEL_W-1:0] FWD_EX_RES = 3'b001;
    localparam logic [SEL_W-1:0] FWD_EX_IMM = 3'b010;
    localparam logic [SEL_W-1:0] FWD_MEM    = 3'b011;
    localparam logic [SEL_W-1:0] FWD_WB     = 3'b100;

    typedef struct packed {
        logic             valid_we;
        logic [REG_W-1:0] rd;
        logic [WD_W-1:0]  wd_sel;
    } sb_slot_t;

    // A slot matches a source register only when it will really write it.
    function automatic logic slot_hit(input sb_slot_t slot, input logic [REG_W-1:0] rs);
        return slot.valid_we && (slot.rd == rs);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding select and load/link-use hazard detection.
// Ports:
//   rs, used                 source register of the ID instruction and whether it is read
//   ex_slot/mem_slot/wb_slot scoreboard slots, youngest first
//   sel_c                    forwarding select (combinational)
//   hazard_c                 EX producer cannot forward yet (combinational)
module hazard_fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic             used,
    input  sb_slot_t         ex_slot,
    input  sb_slot_t         mem_slot,
    input  sb_slot_t         wb_slot,
    output logic [SEL_W-1:0] sel_c,
    output logic             hazard_c
);

    // From MEM onward every writeback source is available, so only EX cares about wd_sel.
    logic unused_wd_sel;
    assign unused_wd_sel = ^{mem_slot.wd_sel, wb_slot.wd_sel};

    // Youngest matching slot wins.
    always_comb begin
        sel_c    = FWD_RF;
        hazard_c = 1'b0;
        if (used && (rs != '0)) begin
            if (slot_hit(ex_slot, rs)) begin
                case (ex_slot.wd_sel)
                    WD_ALU:  sel_c = FWD_EX_RES;
                    WD_IMM:  sel_c = FWD_EX_IMM;
                    default: hazard_c = 1'b1;   // DRAM / PC+4 not ready until MEM
                endcase
            end else if (slot_hit(mem_slot, rs)) begin
                sel_c = FWD_MEM;
            end else if (slot_hit(wb_slot, rs)) begin
                sel_c = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard and forwarding controller for the five-stage pipeline.
// Tracks in-flight destinations (EX/MEM/WB), drives operand forwarding selects,
// raises load-use stalls and taken-branch flushes, and counts both events.
// Ports:
//   clk_cpu, rst_cpu             clock, synchronous active-high reset
//   rs1_id/rs2_id, rs*_used_id   source registers of the ID instruction
//   rd_id, rd_we_id, wd_sel_id   destination info of the ID instruction
//   branch_taken_ex              EX branch/jump resolved taken
//   rD1_sel, rD2_sel             forwarding selects (combinational)
//   stop, bubble, flush_if_id    pipeline control (combinational)
//   stall_cnt, flush_cnt         saturating event counters (registered)
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_cpu,
    input  logic             rst_cpu,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic [4:0]       rd_id,
    input  logic             rd_we_id,
    input  logic [1:0]       wd_sel_id,
    input  logic             branch_taken_ex,
    output logic [2:0]       rD1_sel,
    output logic [2:0]       rD2_sel,
    output logic             stop,
    output logic             bubble,
    output logic             flush_if_id,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    sb_slot_t ex_q, mem_q, wb_q;
    sb_slot_t ex_d;
    logic     hazard1, hazard2, hazard;

    hazard_fwd_sel u_fwd_rs1 (
        .rs       (rs1_id),
        .used     (rs1_used_id),
        .ex_slot  (ex_q),
        .mem_slot (mem_q),
        .wb_slot  (wb_q),
        .sel_c    (rD1_sel),
        .hazard_c (hazard1)
    );

    hazard_fwd_sel u_fwd_rs2 (
        .rs       (rs2_id),
        .used     (rs2_used_id),
        .ex_slot  (ex_q),
        .mem_slot (mem_q),
        .wb_slot  (wb_q),
        .sel_c    (rD2_sel),
        .hazard_c (hazard2)
    );

    assign hazard = hazard1 | hazard2;

    // Pipeline control; a taken branch squashes the hazarding ID instruction instead of stalling.
    always_comb begin
        stop        = 1'b0;
        bubble      = 1'b0;
        flush_if_id = 1'b0;
        if (branch_taken_ex) begin
            bubble      = 1'b1;
            flush_if_id = 1'b1;
        end else if (hazard) begin
            stop   = 1'b1;
            bubble = 1'b1;
        end
    end

    // Next EX slot; x0 writes never become valid so x0 never forwards or stalls.
    always_comb begin
        ex_d          = '0;
        if (!bubble) begin
            ex_d.valid_we = rd_we_id && (rd_id != '0);
            ex_d.rd       = rd_id;
            ex_d.wd_sel   = wd_sel_id;
        end
    end

    // Scoreboard shift register.
    always_ff @(posedge clk_cpu) begin
        if (rst_cpu) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk_cpu) begin
        if (rst_cpu) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stop && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (branch_taken_ex && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver pushes hand-computed expectations
// per cycle, a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int unsigned CNT_W = 4;
    localparam logic [2:0]  DC    = 3'b111;   // select not checked

    logic             clk_cpu = 1'b0;
    logic             rst_cpu = 1'b1;
    logic [4:0]       rs1_id = '0, rs2_id = '0, rd_id = '0;
    logic             rs1_used_id = 1'b0, rs2_used_id = 1'b0, rd_we_id = 1'b0;
    logic [1:0]       wd_sel_id = '0;
    logic             branch_taken_ex = 1'b0;
    logic [2:0]       rD1_sel, rD2_sel;
    logic             stop, bubble, flush_if_id;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_cpu         (clk_cpu),
        .rst_cpu         (rst_cpu),
        .rs1_id          (rs1_id),
        .rs2_id          (rs2_id),
        .rs1_used_id     (rs1_used_id),
        .rs2_used_id     (rs2_used_id),
        .rd_id           (rd_id),
        .rd_we_id        (rd_we_id),
        .wd_sel_id       (wd_sel_id),
        .branch_taken_ex (branch_taken_ex),
        .rD1_sel         (rD1_sel),
        .rD2_sel         (rD2_sel),
        .stop            (stop),
        .bubble          (bubble),
        .flush_if_id     (flush_if_id),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clk_cpu = ~clk_cpu;

    typedef struct {
        logic [2:0] s1;
        logic [2:0] s2;
        logic       st;
        logic       bb;
        logic       fl;
        int         stall;
        int         flush;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // Monitor: outputs are stable mid-cycle, compare there.
    always @(negedge clk_cpu) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (e.s1 != DC) chk({nm, ".rD1_sel"}, int'(rD1_sel), int'(e.s1));
            if (e.s2 != DC) chk({nm, ".rD2_sel"}, int'(rD2_sel), int'(e.s2));
            chk({nm, ".stop"},        int'(stop),        int'(e.st));
            chk({nm, ".bubble"},      int'(bubble),      int'(e.bb));
            chk({nm, ".flush_if_id"}, int'(flush_if_id), int'(e.fl));
            chk({nm, ".stall_cnt"},   int'(stall_cnt),   e.stall);
            chk({nm, ".flush_cnt"},   int'(flush_cnt),   e.flush);
        end
    end

    // Drive one cycle of inputs and queue what the DUT must show during it.
    task automatic cyc(input string nm,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic we, input logic [1:0] wds,
                       input logic br, input logic rst,
                       input logic [2:0] e1, input logic [2:0] e2,
                       input logic est, input logic eb, input logic ef,
                       input int es, input int efl);
        exp_t e;
        rs1_id = rs1; rs1_used_id = u1;
        rs2_id = rs2; rs2_used_id = u2;
        rd_id = rd; rd_we_id = we; wd_sel_id = wds;
        branch_taken_ex = br; rst_cpu = rst;
        e.s1 = e1; e.s2 = e2; e.st = est; e.bb = eb; e.fl = ef;
        e.stall = es; e.flush = efl;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk_cpu);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_cpu = 1'b1;
        repeat (2) @(posedge clk_cpu);
        #1;
        //   name          rs1 u1 rs2 u2 rd we wds      br rst  sel1        sel2     st bb fl stall flush
        cyc("reset",        0, 0, 0, 0, 0, 0, WD_ALU,  0, 0, FWD_RF,     FWD_RF,  0, 0, 0, 0, 0);
        // EX -> MEM -> WB -> RF forwarding of an ALU write to x5
        cyc("alu_x5",       0, 0, 0, 0, 5, 1, WD_ALU,  0, 0, FWD_RF,     FWD_RF,  0, 0, 0, 0, 0);
        cyc("fwd_ex",       5, 1, 0, 0, 0, 0, WD_ALU,  0, 0, FWD_EX_RES, FWD_RF,  0, 0, 0, 0, 0);
        cyc("fwd_mem",      5, 1, 0, 0, 0, 0, WD_ALU,  0, 0, FWD_MEM,    FWD_RF,  0, 0, 0, 0, 0);
        cyc("fwd_wb",       5, 1, 0, 0, 0, 0, WD_ALU,  0, 0, FWD_WB,     FWD_RF,  0, 0, 0, 0, 0);
        cyc("fwd_none",     5, 1, 0, 0, 0, 0, WD_ALU,  0, 0, FWD_RF,     FWD_RF,  0, 0, 0, 0, 0);
        // load-use on x7: one stall, then MEM forward
        cyc("load_x7",      0, 0, 0, 0, 7, 1, WD_DRAM, 0, 0, FWD_RF,     FWD_RF,  0, 0, 0, 0, 0);
        cyc("load_use",     0, 0, 7, 1, 0, 0, WD_ALU,  0, 0, FWD_RF,     DC,      1, 1, 0, 0, 0);
        cyc("after_stall",  0, 0, 7, 1, 0, 0, WD_ALU,  0, 0, FWD_RF,     FWD_MEM, 0, 0, 0, 1, 0);
        // taken branch concurrent with a load-use hazard; ID write to x4 is squashed
        cyc("load_x9",      0, 0, 0, 0, 9, 1, WD_DRAM, 0, 0, FWD_RF,     FWD_RF,  0, 0, 0, 1, 0);
        cyc("br_hazard",    9, 1, 0, 0, 4, 1, WD_ALU,  1, 0, DC,         FWD_RF,  0, 1, 1, 1, 0);
        cyc("post_flush",   4, 1, 9, 1, 0, 0, WD_ALU,  0, 0, FWD_RF,     FWD_MEM, 0, 0, 0, 1, 1);
        // x3 in EX (imm) and WB (alu): youngest wins
        cyc("w_x3_alu",     0, 0, 0, 0, 3, 1, WD_ALU,  0, 0, FWD_RF,     FWD_RF,  0, 0, 0, 1, 1);
        cyc("idle",         0, 0, 0, 0, 0, 0, WD_ALU,  0, 0, FWD_RF,     FWD_RF,  0, 0, 0, 1, 1);
        cyc("w_x3_imm",     0, 0, 3, 1, 3, 1, WD_IMM,  0, 0, FWD_RF,     FWD_MEM, 0, 0, 0, 1, 1);
        cyc("prio_ex_imm",  3, 1, 3, 1, 0, 0, WD_ALU,  0, 0, FWD_EX_IMM, FWD_EX_IMM, 0, 0, 0, 1, 1);
        // load to x0 never stalls or forwards
        cyc("w_x0",         0, 0, 0, 0, 0, 1, WD_DRAM, 0, 0, FWD_RF,     FWD_RF,  0, 0, 0, 1, 1);
        cyc("read_x0",      0, 1, 0, 1, 0, 0, WD_ALU,  0, 0, FWD_RF,     FWD_RF,  0, 0, 0, 1, 1);
        // repeated load-use pairs until the 4-bit stall counter saturates at 15
        for (int i = 0; i < 32; i++) begin
            int es;
            es = (1 + i / 2 > 15) ? 15 : 1 + i / 2;
            if (i % 2 == 0)
                cyc("sat_nostall", 0, 0, 7, 1, 7, 1, WD_DRAM, 0, 0,
                    FWD_RF, (i == 0) ? FWD_RF : FWD_MEM, 0, 0, 0, es, 1);
            else
                cyc("sat_stall",   0, 0, 7, 1, 7, 1, WD_DRAM, 0, 0,
                    FWD_RF, DC, 1, 1, 0, es, 1);
        end
        cyc("sat_hold",     0, 0, 7, 1, 7, 1, WD_DRAM, 0, 0, FWD_RF,     FWD_MEM, 0, 0, 0, 15, 1);
        // reset asserted during an active stall
        cyc("rst_in_stall", 0, 0, 7, 1, 7, 1, WD_DRAM, 0, 1, FWD_RF,     DC,      1, 1, 0, 15, 1);
        cyc("post_reset",   7, 1, 7, 1, 0, 0, WD_ALU,  0, 0, FWD_RF,     FWD_RF,  0, 0, 0, 0, 0);
        @(negedge clk_cpu);
        @(negedge clk_cpu);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and forwarding controller for the five-stage RISC-V pipeline, sitting in the decode stage directly upstream of the ID/EX pipeline register. It keeps a three-deep scoreboard of in-flight destination registers (EX, MEM, WB) and, from the source registers of the instruction in ID, drives the per-operand forwarding selects that ID/EX uses to pick its rD1/rD2 source. It also raises load-use stalls and taken-branch flushes, and keeps saturating stall and flush event counters.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk_cpu  in  1  pipeline clock; all state updates on its rising edge.
- rst_cpu  in  1  reset, synchronous, active-high.
- rs1_id  in  5  rs1 of the instruction in ID.
- rs2_id  in  5  rs2 of the instruction in ID.
- rs1_used_id  in  1  the ID instruction reads rs1.
- rs2_used_id  in  1  the ID instruction reads rs2.
- rd_id  in  5  destination register of the ID instruction.
- rd_we_id  in  1  the ID instruction writes rd.
- wd_sel_id  in  2  writeback source of the ID instruction: 00 ALU, 01 DRAM, 10 PC+4, 11 immediate.
- branch_taken_ex  in  1  the EX-stage branch or jump resolved taken this cycle.
- rD1_sel  out  3  forwarding select for operand 1.
- rD2_sel  out  3  forwarding select for operand 2.
- stop  out  1  freeze PC and IF/ID this cycle.
- bubble  out  1  load a bubble into ID/EX at the next edge.
- flush_if_id  out  1  clear IF/ID at the next edge.
- stall_cnt  out  CNT_W  count of cycles with stop=1.
- flush_cnt  out  CNT_W  count of cycles with branch_taken_ex=1.

## Operation
- The scoreboard has three slots: EX, MEM and WB. Each slot holds {valid_we, rd[4:0], wd_sel[1:0]}.
- At each clock edge the slots advance: WB takes MEM, and MEM takes EX.
- EX takes {rd_we_id & (rd_id≠0), rd_id, wd_sel_id}. When bubble=1, EX takes all zeros instead.
- Per-operand select, rsN with usedN=1 and rsN≠0. Priority is EX, then MEM, then WB, then none:
  - EX match with wd_sel 00 → 001 (EX ALU result).
  - EX match with wd_sel 11 → 010 (EX immediate).
  - EX match with wd_sel 01 or 10 → load/link-use hazard; the select is a don't-care.
  - MEM match → 011 (MEM-stage write data).
  - WB match → 100 (WB write data).
  - No match → 000 (register file).
- If usedN=0 or rsN=0, the select is 000.
- hazard = either operand has a load/link-use hazard.
- If branch_taken_ex=1: stop=0, bubble=1, flush_if_id=1. The branch takes priority over any hazard.
- Else if hazard=1: stop=1, bubble=1, flush_if_id=0. This is always a single-cycle stall; next cycle the producer is in MEM and forwards via 011.
- Otherwise stop, bubble and flush_if_id are all 0.
- stall_cnt increments on each cycle with stop=1. flush_cnt increments on each cycle with branch_taken_ex=1. Both saturate at all-ones and never wrap.

## Timing
- Selects, stop, bubble and flush_if_id are combinational from the current inputs and scoreboard state, with zero latency. ID/EX samples them at the same edge.
- The scoreboard and counters are registered and update at the rising edge of clk_cpu.
- Reset (rst_cpu=1 at an edge):
  - All slots are cleared to 0 and both counters go to 0.
  - Combinational outputs follow from the cleared state, so rD*_sel=000 and stop=bubble=flush_if_id=0 unless the current inputs demand otherwise.
- Reset mid-stall discards the in-flight scoreboard. There is no stall carry-over after reset.
- The same rd in several slots resolves to the youngest slot (EX first).
- A write to x0 never marks a slot valid, so x0 never forwards and never stalls.
- A branch and a hazard in the same cycle: the stall is suppressed and the hazarding ID instruction is flushed.
- Back-to-back loads to the same rd: each consumer stalls exactly once.

## Structure
- A shared package holds:
  - the wd_sel encodings (WD_ALU, WD_DRAM, WD_PC4, WD_IMM);
  - the forwarding select encodings (FWD_RF, FWD_EX_RES, FWD_EX_IMM, FWD_MEM, FWD_WB);
  - the scoreboard-slot struct.
- One sub-module, hazard_fwd_sel, is instantiated twice (once per operand). It takes {rs, used, three slots} and returns {sel, hazard}.
- The scoreboard shift register and the counters live in the top module.

## Test plan
- Forwarding from EX, MEM and WB:
  - Stimulus: ALU write x5 (wd_sel=00) enters EX; ID reads rs1=5, used=1.
  - Required: rD1_sel=001, no stop.
  - One cycle later (producer in MEM): rD1_sel=011.
  - Two cycles later (producer in WB): rD1_sel=100.
  - Three cycles later: rD1_sel=000.
- Load-use: a load to x7 is in EX and ID reads rs2=7 → stop=1, bubble=1 for exactly one cycle; next cycle rD2_sel=011, stop=0, and stall_cnt=1.
- Branch flush with a simultaneous hazard: branch_taken_ex=1 while a load-use hazard exists → stop=0, bubble=1, flush_if_id=1, flush_cnt increments, and the next cycle's EX slot is invalid.
- Priority and x0:
  - x3 is written in both EX (imm) and WB; ID reads rs1=3 → rD1_sel=010.
  - rd=0 with rd_we=1, followed by a read of x0 → rD1_sel=000, no stall.
- Saturation: with CNT_W=4, hold a hazard condition for 20 cycles → stall_cnt stops at 15.
- Reset mid-stall: assert rst_cpu during an active stall → next cycle stall_cnt=0, the scoreboard is empty, and all selects are 000.
